// File: rtl/event_hub_pkg.sv
`default_nettype none
// =============================================================================
// Module   : event_hub_pkg
// Brief    : Shared defaults, ID width helper and alias-table entry type.
// Revision : 1.0
// =============================================================================
package event_hub_pkg;

    localparam int unsigned NUM_EVT_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT   = 4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Entry layout at the default channel count; the hub declares the same
    // layout at its own parameterised width.
    typedef struct packed {
        logic                                   is_null;
        logic [id_width(NUM_EVT_DEFAULT)-1:0]   dst;
    } alias_entry_t;

endpackage
`default_nettype wire

// File: rtl/event_counter.sv
`default_nettype none
// =============================================================================
// Module   : event_counter
// Brief    : Saturating up-by-n / down-by-1 counter with sticky overflow and a
//            registered one-cycle "fired" flag.
// Revision : 1.0
// =============================================================================
module event_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned INC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc_n,
    input  logic             dec,
    output logic [CNT_W-1:0] count_o,
    output logic             fired_o,
    output logic             ovf_o
);

    localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] C_MAX = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_d, count_q;
    logic             fired_d, fired_q;
    logic             ovf_d,   ovf_q;
    logic [SUM_W-1:0] w_sum;

    // Net change is applied before saturation so +n-1 clips only once.
    always_comb begin
        w_sum = SUM_W'(count_q) + SUM_W'(inc_n);
        if (dec && (w_sum != '0)) begin
            w_sum = w_sum - SUM_W'(1);
        end
        ovf_d = ovf_q;
        if (w_sum > C_MAX) begin
            count_d = C_MAX[CNT_W-1:0];
            ovf_d   = 1'b1;
        end else begin
            count_d = w_sum[CNT_W-1:0];
        end
        fired_d = (inc_n != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            fired_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            fired_q <= fired_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign fired_o = fired_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/event_hub.sv
`default_nettype none
// =============================================================================
// Module   : event_hub
// Brief    : Event channels with a single-level alias table, saturating pending
//            counters and a valid/ready waiter port.
// Revision : 1.0
// =============================================================================
module event_hub
    import event_hub_pkg::*;
#(
    parameter  int unsigned NUM_EVT = NUM_EVT_DEFAULT,
    parameter  int unsigned CNT_W   = CNT_W_DEFAULT,
    localparam int unsigned ID_W    = id_width(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] trig_i,
    input  logic               alias_we,
    input  logic [ID_W-1:0]    alias_src,
    input  logic [ID_W-1:0]    alias_dst,
    input  logic               alias_null,
    input  logic               wait_valid,
    input  logic [ID_W-1:0]    wait_id,
    output logic               wait_ready,
    output logic               wait_null,
    output logic [NUM_EVT-1:0] triggered_o,
    output logic [NUM_EVT-1:0] ovf_o
);

    localparam int unsigned INC_W = $clog2(NUM_EVT + 1);

    typedef struct packed {
        logic            is_null;
        logic [ID_W-1:0] dst;
    } entry_t;

    entry_t             alias_d [NUM_EVT];
    entry_t             alias_q [NUM_EVT];
    entry_t             w_wait_ent;
    logic [INC_W-1:0]   w_inc   [NUM_EVT];
    logic [CNT_W-1:0]   w_count [NUM_EVT];
    logic [NUM_EVT-1:0] w_dec;
    logic [NUM_EVT-1:0] w_nonzero;
    logic               w_hit;

    always_comb begin
        for (int k = 0; k < NUM_EVT; k++) begin
            alias_d[k] = alias_q[k];
            if (alias_we && (alias_src == ID_W'(k))) begin
                alias_d[k] = '{is_null: alias_null, dst: alias_dst};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rst) begin
                alias_q[k] <= '{is_null: 1'b0, dst: ID_W'(k)};
            end else begin
                alias_q[k] <= alias_d[k];
            end
        end
    end

    // Per-destination popcount of this cycle's triggers under the current map.
    always_comb begin
        for (int j = 0; j < NUM_EVT; j++) begin
            w_inc[j] = '0;
            for (int k = 0; k < NUM_EVT; k++) begin
                if (trig_i[k] && !alias_q[k].is_null && (alias_q[k].dst == ID_W'(j))) begin
                    w_inc[j] = w_inc[j] + INC_W'(1);
                end
            end
        end
    end

    // An ID with no table slot behaves as a null channel.
    always_comb begin
        w_wait_ent = '{is_null: 1'b1, dst: '0};
        for (int k = 0; k < NUM_EVT; k++) begin
            if (wait_id == ID_W'(k)) begin
                w_wait_ent = alias_q[k];
            end
        end
        w_hit = 1'b0;
        for (int j = 0; j < NUM_EVT; j++) begin
            if (!w_wait_ent.is_null && (w_wait_ent.dst == ID_W'(j)) && w_nonzero[j]) begin
                w_hit = 1'b1;
            end
        end
    end

    assign wait_ready = wait_valid && !rst && (w_wait_ent.is_null || w_hit);
    assign wait_null  = wait_ready && w_wait_ent.is_null;

    always_comb begin
        for (int j = 0; j < NUM_EVT; j++) begin
            w_dec[j] = wait_ready && !w_wait_ent.is_null && (w_wait_ent.dst == ID_W'(j));
        end
    end

    for (genvar j = 0; j < NUM_EVT; j++) begin : g_chan
        event_counter #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_n   (w_inc[j]),
            .dec     (w_dec[j]),
            .count_o (w_count[j]),
            .fired_o (triggered_o[j]),
            .ovf_o   (ovf_o[j])
        );
        assign w_nonzero[j] = (w_count[j] != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_event_hub.sv
`default_nettype none
// =============================================================================
// Module   : tb_event_hub
// Brief    : Scoreboard bench for event_hub (NUM_EVT=8, CNT_W=4).
// Revision : 1.0
// =============================================================================
module tb_event_hub;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] trg;
        logic         wv;
        logic [2:0]   wid;
        logic         awe;
        logic [2:0]   asrc;
        logic [2:0]   adst;
        logic         an;
    } stim_t;

    typedef struct {
        logic         rdy;
        logic         nul;
        logic [N-1:0] trg;
        logic [N-1:0] ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] trig_i;
    logic         alias_we;
    logic [2:0]   alias_src;
    logic [2:0]   alias_dst;
    logic         alias_null;
    logic         wait_valid;
    logic [2:0]   wait_id;
    logic         wait_ready;
    logic         wait_null;
    logic [N-1:0] triggered_o;
    logic [N-1:0] ovf_o;

    event_hub #(.NUM_EVT(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_i      (trig_i),
        .alias_we    (alias_we),
        .alias_src   (alias_src),
        .alias_dst   (alias_dst),
        .alias_null  (alias_null),
        .wait_valid  (wait_valid),
        .wait_id     (wait_id),
        .wait_ready  (wait_ready),
        .wait_null   (wait_null),
        .triggered_o (triggered_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int           vectors     = 0;
    int           miscompares = 0;
    exp_t         sb[$];
    logic         obs_rdy;
    logic         obs_nul;
    int           m_pend [N];
    int           m_dst  [N];
    logic         m_null [N];
    logic [N-1:0] m_ovf;

    function automatic stim_t st(input logic [N-1:0] trg, input logic wv, input logic [2:0] wid);
        st     = '0;
        st.trg = trg;
        st.wv  = wv;
        st.wid = wid;
    endfunction

    function automatic stim_t aw(input logic [2:0] src, input logic [2:0] dst, input logic an);
        aw      = '0;
        aw.awe  = 1'b1;
        aw.asrc = src;
        aw.adst = dst;
        aw.an   = an;
    endfunction

    task automatic idle();
        trig_i = '0; wait_valid = 1'b0; wait_id = 3'd0;
        alias_we = 1'b0; alias_src = 3'd0; alias_dst = 3'd0; alias_null = 1'b0;
    endtask

    // Drives one cycle, predicts the outcome from the reference model and
    // queues it; the calling test pops and compares once the edge has passed.
    task automatic cycle(input stim_t s);
        exp_t e;
        int   n [N];
        int   r;
        int   v;
        trig_i = s.trg; wait_valid = s.wv; wait_id = s.wid;
        alias_we = s.awe; alias_src = s.asrc; alias_dst = s.adst; alias_null = s.an;
        #1;
        obs_rdy = wait_ready;
        obs_nul = wait_null;
        r     = m_dst[s.wid];
        e.rdy = s.wv && (m_null[s.wid] || (m_pend[r] > 0));
        e.nul = s.wv && m_null[s.wid];
        e.trg = '0;
        for (int j = 0; j < N; j++) n[j] = 0;
        for (int k = 0; k < N; k++) begin
            if (s.trg[k] && !m_null[k]) begin
                n[m_dst[k]]++;
                e.trg[m_dst[k]] = 1'b1;
            end
        end
        if (e.rdy && !e.nul) n[r]--;
        for (int j = 0; j < N; j++) begin
            v = m_pend[j] + n[j];
            if (v > 15) begin
                v = 15;
                m_ovf[j] = 1'b1;
            end
            m_pend[j] = v;
        end
        if (s.awe) begin
            m_null[s.asrc] = s.an;
            m_dst[s.asrc]  = int'(s.adst);
        end
        e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk); #1;
        idle();
    endtask

    // Reset cycle with triggers, an alias write and a wait presented, all of
    // which must be ignored.
    task automatic apply_reset(input logic [2:0] wid, output logic rdy_in_rst);
        rst = 1'b1;
        trig_i = '1; wait_valid = 1'b1; wait_id = wid;
        alias_we = 1'b1; alias_src = 3'd0; alias_dst = 3'd3; alias_null = 1'b1;
        #1;
        rdy_in_rst = wait_ready;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0; m_dst[k] = k; m_null[k] = 1'b0;
        end
        m_ovf = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        stim_t tab[2];
        exp_t  e;
        logic  r;
        int    grants = 0;
        apply_reset(3'd0, r);
        vectors++;
        if (r !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got %b, want 0", r);
        end
        vectors++;
        if ({triggered_o, ovf_o} !== 16'h0000) begin
            miscompares++; $display("FAIL reset_outputs: got trg=%h ovf=%h, want 00 00", triggered_o, ovf_o);
        end
        tab = '{st(8'h00, 1'b1, 3'd0), st(8'h00, 1'b1, 3'd5)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL reset_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 0) begin
            miscompares++; $display("FAIL reset_grants: got %0d, want 0", grants);
        end
    endtask

    task automatic test_basic();
        stim_t tab[3];
        exp_t  e;
        int    grants = 0;
        tab = '{st(8'h01, 1'b1, 3'd0), st(8'h00, 1'b1, 3'd0), st(8'h00, 1'b1, 3'd0)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL basic_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 1) begin
            miscompares++; $display("FAIL basic_grants: got %0d, want 1", grants);
        end
    endtask

    task automatic test_alias();
        stim_t tab[5];
        exp_t  e;
        int    grants = 0;
        // Trigger in the write cycle still uses the identity mapping.
        tab = '{aw(3'd3, 3'd5, 1'b0), st(8'h08, 1'b0, 3'd0), st(8'h00, 1'b1, 3'd3),
                st(8'h00, 1'b1, 3'd5), st(8'h00, 1'b1, 3'd3)};
        tab[0].trg = 8'h08;
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL alias_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 1) begin
            miscompares++; $display("FAIL alias_grants: got %0d, want 1", grants);
        end
    endtask

    task automatic test_fanin();
        stim_t tab[7];
        exp_t  e;
        int    grants = 0;
        tab = '{aw(3'd1, 3'd0, 1'b0), aw(3'd2, 3'd0, 1'b0), st(8'h07, 1'b0, 3'd0),
                st(8'h00, 1'b1, 3'd0), st(8'h00, 1'b1, 3'd0), st(8'h00, 1'b1, 3'd0),
                st(8'h00, 1'b1, 3'd0)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL fanin_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 3) begin
            miscompares++; $display("FAIL fanin_grants: got %0d, want 3", grants);
        end
    endtask

    task automatic test_null();
        stim_t tab[4];
        exp_t  e;
        int    nulls = 0;
        tab = '{aw(3'd4, 3'd0, 1'b1), st(8'h10, 1'b0, 3'd0), st(8'h00, 1'b1, 3'd4),
                st(8'h10, 1'b1, 3'd4)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL null_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            nulls += int'(obs_rdy && obs_nul);
        end
        vectors++;
        if (nulls !== 2) begin
            miscompares++; $display("FAIL null_completions: got %0d, want 2", nulls);
        end
    endtask

    task automatic test_back_to_back();
        stim_t tab[4];
        exp_t  e;
        int    grants = 0;
        tab = '{st(8'h80, 1'b1, 3'd7), st(8'h80, 1'b1, 3'd7), st(8'h00, 1'b1, 3'd7),
                st(8'h00, 1'b1, 3'd7)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL b2b_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 2) begin
            miscompares++; $display("FAIL b2b_grants: got %0d, want 2", grants);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic r;
        int   grants = 0;
        apply_reset(3'd1, r);
        for (int i = 0; i < 33; i++) begin
            cycle((i < 17) ? st(8'h04, 1'b0, 3'd0) : st(8'h00, 1'b1, 3'd2));
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL sat_step[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 15 || ovf_o !== 8'h04) begin
            miscompares++; $display("FAIL sat_final: got grants=%0d ovf=%h, want 15 04", grants, ovf_o);
        end
    endtask

    task automatic test_reset_midflight();
        stim_t pre[4];
        stim_t post[3];
        exp_t  e;
        logic  r;
        int    grants = 0;
        pre  = '{st(8'h40, 1'b0, 3'd0), st(8'h40, 1'b0, 3'd0), aw(3'd6, 3'd1, 1'b0),
                 st(8'h40, 1'b0, 3'd0)};
        foreach (pre[i]) begin
            cycle(pre[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL mid_pre[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
        end
        apply_reset(3'd6, r);
        vectors++;
        if (r !== 1'b0 || ovf_o !== 8'h00) begin
            miscompares++; $display("FAIL mid_reset: got rdy=%b ovf=%h, want 0 00", r, ovf_o);
        end
        post = '{st(8'h00, 1'b1, 3'd6), st(8'h40, 1'b0, 3'd0), st(8'h00, 1'b1, 3'd6)};
        foreach (post[i]) begin
            cycle(post[i]);
            e = sb.pop_front();
            vectors++;
            if ({obs_rdy, obs_nul, triggered_o, ovf_o} !== {e.rdy, e.nul, e.trg, e.ovf}) begin
                miscompares++;
                $display("FAIL mid_post[%0d]: got rdy=%b nul=%b trg=%h ovf=%h, want rdy=%b nul=%b trg=%h ovf=%h",
                         i, obs_rdy, obs_nul, triggered_o, ovf_o, e.rdy, e.nul, e.trg, e.ovf);
            end
            grants += int'(obs_rdy);
        end
        vectors++;
        if (grants !== 1) begin
            miscompares++; $display("FAIL mid_grants: got %0d, want 1", grants);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_alias();
        test_fanin();
        test_null();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
